// File: rtl/video_pkg.sv
// Shared video definitions for the scaler output path.
//   state_e   : line normaliser FSM states (IDLE/ACT/FILL/TRUNC)
//   pixel_t   : pixel word, PIX_W bits
//   PIX_BLACK : all-zero pixel, default fill colour
package video_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACT   = 2'd1,
    FILL  = 2'd2,
    TRUNC = 2'd3
  } state_e;

  localparam int PIX_W = 24;

  typedef logic [PIX_W-1:0] pixel_t;

  localparam pixel_t PIX_BLACK = '0;

endpackage

// File: rtl/line_len_cnt.sv
// Output-pixel counter for one line plus its compare against the latched
// line length.
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   load_i     : first pixel of a line is emitted, counter becomes 1
//   inc_i      : one more pixel emitted (saturates at all-ones)
//   h_disp_i   : latched target line length
//   done_o     : counter equals the line length (line complete)
//   last_o     : the next increment completes the line
module line_len_cnt #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] h_disp_i,
  output logic             done_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             sat;

  always_comb begin
    sat   = (cnt_q == '1);
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(1);
    end else if (inc_i && !sat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == h_disp_i);
  // Widened by one bit so the compare cannot wrap at the counter maximum.
  assign last_o = (({1'b0, cnt_q} + (CNT_W + 1)'(1)) == {1'b0, h_disp_i});

endmodule

// File: rtl/line_pad_trunc.sv
// Per-line horizontal normaliser: every input valid burst becomes exactly
// h_disp contiguous output pixels (short lines padded, long lines cut).
// Optional feature macro: LINE_PAD_STATS_EN (adds last_len_o, err_cnt_o).
//   clk, rst_n   : pixel clock, asynchronous active-low reset
//   h_disp_i     : target line length, sampled at each line start
//   data_i       : input pixel, dataValid_i marks a line burst
//   err_clr_i    : synchronous clear of the sticky flags
//   data_o       : output pixel (PAD_COLOR during fill), dataValid_o valid
//   line_done_o  : pulse with pixel h_disp of each line
//   trunc_err_o  : sticky, an input line was longer than h_disp
//   short_err_o  : sticky, a new line started during fill
//   last_len_o   : (stats) input length of the last burst, saturating
//   err_cnt_o    : (stats) count of trunc/short events, saturating at 255
module line_pad_trunc
  import video_pkg::*;
#(
  parameter int                DATA_W    = 24,
  parameter int                CNT_W     = 12,
  parameter logic [CNT_W-1:0]  H_DISP    = CNT_W'(1920),
  parameter logic [DATA_W-1:0] PAD_COLOR = DATA_W'(PIX_BLACK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  h_disp_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              dataValid_i,
  input  logic              err_clr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              dataValid_o,
  output logic              line_done_o,
  output logic              trunc_err_o,
  output logic              short_err_o
`ifdef LINE_PAD_STATS_EN
  ,
  output logic [CNT_W-1:0]  last_len_o,
  output logic [7:0]        err_cnt_o
`endif
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  h_disp_q, h_disp_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              vld_q, vld_d;
  logic              done_q, done_d;
  logic              trunc_q, trunc_d;
  logic              short_q, short_d;

  logic emit, pad, start, load, inc;
  logic trunc_evt, short_evt;
  logic cnt_done, cnt_last;

  line_len_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .inc_i   (inc),
    .h_disp_i(h_disp_q),
    .done_o  (cnt_done),
    .last_o  (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    h_disp_d  = h_disp_q;
    emit      = 1'b0;
    pad       = 1'b0;
    start     = 1'b0;
    load      = 1'b0;
    inc       = 1'b0;
    done_d    = 1'b0;
    trunc_evt = 1'b0;
    short_evt = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dataValid_i) start = 1'b1;
      end
      ACT: begin
        if (dataValid_i) begin
          if (cnt_done) begin
            trunc_evt = 1'b1;
            state_d   = TRUNC;
          end else begin
            emit   = 1'b1;
            inc    = 1'b1;
            done_d = cnt_last;
          end
        end else if (cnt_done) begin
          state_d = IDLE;
        end else begin
          // First pad pixel goes out in the same cycle valid drops.
          pad     = 1'b1;
          inc     = 1'b1;
          done_d  = cnt_last;
          state_d = cnt_last ? IDLE : FILL;
        end
      end
      FILL: begin
        if (dataValid_i) begin
          // A new line beats the pending fill; the old line gets no done.
          short_evt = 1'b1;
          start     = 1'b1;
        end else begin
          pad     = 1'b1;
          inc     = 1'b1;
          done_d  = cnt_last;
          state_d = cnt_last ? IDLE : FILL;
        end
      end
      TRUNC: begin
        if (!dataValid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      h_disp_d = h_disp_i;
      if (h_disp_i == '0) begin
        state_d = TRUNC;
      end else begin
        emit    = 1'b1;
        load    = 1'b1;
        done_d  = (h_disp_i == CNT_W'(1));
        state_d = ACT;
      end
    end

    vld_d  = emit | pad;
    data_d = emit ? data_i : (pad ? PAD_COLOR : '0);

    // Set wins over a simultaneous clear.
    trunc_d = (trunc_q & ~err_clr_i) | trunc_evt;
    short_d = (short_q & ~err_clr_i) | short_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      h_disp_q <= H_DISP;
      data_q   <= '0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
      trunc_q  <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_disp_q <= h_disp_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
      trunc_q  <= trunc_d;
      short_q  <= short_d;
    end
  end

  assign data_o      = data_q;
  assign dataValid_o = vld_q;
  assign line_done_o = done_q;
  assign trunc_err_o = trunc_q;
  assign short_err_o = short_q;

`ifdef LINE_PAD_STATS_EN
  logic             in_prev_q, in_prev_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] last_len_q, last_len_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  always_comb begin
    in_prev_d  = dataValid_i;
    in_cnt_d   = in_cnt_q;
    last_len_d = last_len_q;
    err_cnt_d  = err_clr_i ? 8'd0 : err_cnt_q;

    if (dataValid_i) begin
      if (!in_prev_q)           in_cnt_d = CNT_W'(1);
      else if (in_cnt_q != '1)  in_cnt_d = in_cnt_q + CNT_W'(1);
    end else if (in_prev_q) begin
      last_len_d = in_cnt_q;
    end

    if ((trunc_evt || short_evt) && (err_cnt_d != 8'hFF)) begin
      err_cnt_d = err_cnt_d + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_prev_q  <= 1'b0;
      in_cnt_q   <= '0;
      last_len_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      in_prev_q  <= in_prev_d;
      in_cnt_q   <= in_cnt_d;
      last_len_q <= last_len_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign last_len_o = last_len_q;
  assign err_cnt_o  = err_cnt_q;
`endif

endmodule

// File: tb/tb_line_pad_trunc.sv
module tb_line_pad_trunc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] h_disp_i;
  logic [23:0] data_i;
  logic        dataValid_i;
  logic        err_clr_i;
  logic [23:0] data_o;
  logic        dataValid_o;
  logic        line_done_o;
  logic        trunc_err_o;
  logic        short_err_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  line_pad_trunc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .h_disp_i   (h_disp_i),
    .data_i     (data_i),
    .dataValid_i(dataValid_i),
    .err_clr_i  (err_clr_i),
    .data_o     (data_o),
    .dataValid_o(dataValid_o),
    .line_done_o(line_done_o),
    .trunc_err_o(trunc_err_o),
    .short_err_o(short_err_o)
  );

  // One input cycle; outputs are sampled 1 time unit after the edge, so they
  // show the registered result of this cycle's input.
  task automatic cyc(input bit v, input logic [23:0] d);
    @(negedge clk);
    dataValid_i = v;
    data_i      = v ? d : 24'hAAAAAA;
    @(posedge clk);
    #1;
  endtask

  // Data is only meaningful while valid is expected.
  task automatic chk_out(input string tag, input bit v, input logic [23:0] d, input bit dn);
    logic [25:0] obs, exp;
    obs = {dataValid_o, line_done_o, (v ? data_o : 24'h0)};
    exp = {v, dn, (v ? d : 24'h0)};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed vld=%0b done=%0b data=%06h expected vld=%0b done=%0b data=%06h",
             tag, obs[25], obs[24], obs[23:0], exp[25], exp[24], exp[23:0]);
    end
  endtask

  task automatic chk_flags(input string tag, input bit t, input bit s);
    n_assert++;
    assert ({trunc_err_o, short_err_o} === {t, s}) else begin
      n_fail++;
      $error("FAIL %s: observed trunc=%0b short=%0b expected trunc=%0b short=%0b",
             tag, trunc_err_o, short_err_o, t, s);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    h_disp_i    = 12'd8;
    data_i      = 24'h0;
    dataValid_i = 1'b0;
    err_clr_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    assert ({data_o, dataValid_o, line_done_o, trunc_err_o, short_err_o} === 28'h0) else begin
      n_fail++;
      $error("FAIL reset_outputs: observed %07h expected 0",
             {data_o, dataValid_o, line_done_o, trunc_err_o, short_err_o});
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Short line: 5 pixels padded to 8, done on the 8th.
    h_disp_i = 12'd8;
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 24'(i));
      chk_out("t1_data", 1'b1, 24'(i), 1'b0);
    end
    cyc(1'b0, 24'h0); chk_out("t1_pad6", 1'b1, 24'h0, 1'b0);
    cyc(1'b0, 24'h0); chk_out("t1_pad7", 1'b1, 24'h0, 1'b0);
    cyc(1'b0, 24'h0); chk_out("t1_pad8_done", 1'b1, 24'h0, 1'b1);
    cyc(1'b0, 24'h0); chk_out("t1_idle", 1'b0, 24'h0, 1'b0);
    chk_flags("t1_flags", 1'b0, 1'b0);

    // Long line: 6 pixels cut to 4; clear coincident with the set loses.
    h_disp_i = 12'd4;
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 24'h10 + 24'(i));
      chk_out("t2_data", 1'b1, 24'h10 + 24'(i), i == 4);
    end
    err_clr_i = 1'b1;
    cyc(1'b1, 24'h15);
    err_clr_i = 1'b0;
    chk_out("t2_drop5", 1'b0, 24'h0, 1'b0);
    chk_flags("t2_trunc_set_wins", 1'b1, 1'b0);
    cyc(1'b1, 24'h16); chk_out("t2_drop6", 1'b0, 24'h0, 1'b0);
    cyc(1'b0, 24'h0);  chk_out("t2_idle", 1'b0, 24'h0, 1'b0);
    chk_flags("t2_trunc_sticky", 1'b1, 1'b0);
    err_clr_i = 1'b1;
    cyc(1'b0, 24'h0);
    err_clr_i = 1'b0;
    chk_flags("t2_clear", 1'b0, 1'b0);

    // Gap inside a line: 3 data + 2 pad, new line aborts the fill.
    h_disp_i = 12'd8;
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b1, 24'h20 + 24'(i));
      chk_out("t3_l1_data", 1'b1, 24'h20 + 24'(i), 1'b0);
    end
    cyc(1'b0, 24'h0); chk_out("t3_l1_pad", 1'b1, 24'h0, 1'b0);
    cyc(1'b0, 24'h0); chk_out("t3_l1_pad", 1'b1, 24'h0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b1, 24'h30 + 24'(i));
      chk_out("t3_l2_data", 1'b1, 24'h30 + 24'(i), 1'b0);
      if (i == 1) chk_flags("t3_short_set", 1'b0, 1'b1);
    end
    for (int i = 4; i <= 8; i++) begin
      cyc(1'b0, 24'h0);
      chk_out("t3_l2_pad", 1'b1, 24'h0, i == 8);
    end
    cyc(1'b0, 24'h0); chk_out("t3_idle", 1'b0, 24'h0, 1'b0);
    chk_flags("t3_flags", 1'b0, 1'b1);
    err_clr_i = 1'b1;
    cyc(1'b0, 24'h0);
    err_clr_i = 1'b0;
    chk_flags("t3_clear", 1'b0, 1'b0);

    // Exact-length lines back to back with a 1-cycle gap.
    h_disp_i = 12'd4;
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 24'h40 + 24'(i));
      chk_out("t4_l1_data", 1'b1, 24'h40 + 24'(i), i == 4);
    end
    cyc(1'b0, 24'h0); chk_out("t4_gap", 1'b0, 24'h0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 24'h50 + 24'(i));
      chk_out("t4_l2_data", 1'b1, 24'h50 + 24'(i), i == 4);
    end
    cyc(1'b0, 24'h0); chk_out("t4_idle", 1'b0, 24'h0, 1'b0);
    chk_flags("t4_flags", 1'b0, 1'b0);

    // h_disp_i changes mid-line: current line keeps 8, next line is 3.
    h_disp_i = 12'd8;
    cyc(1'b1, 24'h61); chk_out("t5_data", 1'b1, 24'h61, 1'b0);
    cyc(1'b1, 24'h62); chk_out("t5_data", 1'b1, 24'h62, 1'b0);
    h_disp_i = 12'd3;
    for (int i = 3; i <= 5; i++) begin
      cyc(1'b1, 24'h60 + 24'(i));
      chk_out("t5_data_after_change", 1'b1, 24'h60 + 24'(i), 1'b0);
    end
    for (int i = 6; i <= 8; i++) begin
      cyc(1'b0, 24'h0);
      chk_out("t5_pad", 1'b1, 24'h0, i == 8);
    end
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b1, 24'h70 + 24'(i));
      chk_out("t5_next_line", 1'b1, 24'h70 + 24'(i), i == 3);
    end
    cyc(1'b0, 24'h0); chk_out("t5_idle", 1'b0, 24'h0, 1'b0);
    chk_flags("t5_flags", 1'b0, 1'b0);

    // h_disp = 1: a single pixel line carries the done pulse.
    h_disp_i = 12'd1;
    cyc(1'b1, 24'h81); chk_out("t6_hd1_done", 1'b1, 24'h81, 1'b1);
    cyc(1'b0, 24'h0);  chk_out("t6_hd1_idle", 1'b0, 24'h0, 1'b0);
    chk_flags("t6_hd1_flags", 1'b0, 1'b0);

    // h_disp = 0: nothing emitted, no done, no flag.
    h_disp_i = 12'd0;
    cyc(1'b1, 24'h91); chk_out("t7_hd0_a", 1'b0, 24'h0, 1'b0);
    cyc(1'b1, 24'h92); chk_out("t7_hd0_b", 1'b0, 24'h0, 1'b0);
    cyc(1'b0, 24'h0);  chk_out("t7_hd0_idle", 1'b0, 24'h0, 1'b0);
    chk_flags("t7_hd0_flags", 1'b0, 1'b0);

    // Set a flag, then reset asynchronously at the 3rd pixel of a line.
    h_disp_i = 12'd2;
    cyc(1'b1, 24'hA1); chk_out("t8_pre", 1'b1, 24'hA1, 1'b0);
    cyc(1'b1, 24'hA2); chk_out("t8_pre", 1'b1, 24'hA2, 1'b1);
    cyc(1'b1, 24'hA3); chk_out("t8_pre_drop", 1'b0, 24'h0, 1'b0);
    cyc(1'b0, 24'h0);
    chk_flags("t8_pre_flags", 1'b1, 1'b0);
    h_disp_i = 12'd8;
    cyc(1'b1, 24'hB1); chk_out("t8_line", 1'b1, 24'hB1, 1'b0);
    cyc(1'b1, 24'hB2); chk_out("t8_line", 1'b1, 24'hB2, 1'b0);
    @(negedge clk);
    data_i      = 24'hB3;
    dataValid_i = 1'b1;
    rst_n       = 1'b0;
    #1;
    chk_out("t8_in_reset", 1'b0, 24'h0, 1'b0);
    chk_flags("t8_reset_flags", 1'b0, 1'b0);
    dataValid_i = 1'b0;
    cyc(1'b0, 24'h0); chk_out("t8_held_reset", 1'b0, 24'h0, 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    h_disp_i = 12'd2;
    cyc(1'b1, 24'hC1); chk_out("t8_fresh", 1'b1, 24'hC1, 1'b0);
    cyc(1'b1, 24'hC2); chk_out("t8_fresh_done", 1'b1, 24'hC2, 1'b1);
    cyc(1'b0, 24'h0);  chk_out("t8_idle", 1'b0, 24'h0, 1'b0);
    chk_flags("t8_flags_after", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
